// File: rtl/mem_access_unit_pkg.sv
// Shared constants and helpers for the memory-stage access unit.
// Opcodes, MMIO map, return-select encoding and store lane helpers.
package mem_access_unit_pkg;

    localparam logic [6:0]  OPC_LOAD     = 7'h03;
    localparam logic [6:0]  OPC_STORE    = 7'h23;
    localparam logic [31:0] MMIO_CYCLE   = 32'h8000_0010;
    localparam logic [31:0] MMIO_INSTRET = 32'h8000_0014;
    localparam logic [31:0] MMIO_CLEAR   = 32'h8000_0018;
    localparam logic [31:0] NOP_INST     = 32'h0000_0013;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_DMEM = 2'd1,
        SEL_CNT  = 2'd2,
        SEL_IO   = 2'd3
    } sel_t;

    // Byte 0 sits in bits [31:24]; lanes shift right with the offset.
    function automatic logic [3:0] store_we(input logic [1:0] size,
                                            input logic [1:0] off);
        logic [3:0] we;
        case (size)
            SZ_BYTE: we = 4'b1000 >> off;
            SZ_HALF: we = off[1] ? 4'b0011 : 4'b1100;
            default: we = 4'b1111;
        endcase
        return we;
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0]  size,
                                               input logic [31:0] rs2);
        logic [31:0] d;
        case (size)
            SZ_BYTE: d = {4{rs2[7:0]}};
            SZ_HALF: d = {2{rs2[15:0]}};
            default: d = rs2;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_access_unit_counters.sv
// Cycle and retired-instruction counters with a shared clear.
// Clear wins over increment; both keep counting through stalls.
module mmio_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_retire,
    input  logic             i_sel_instret,
    output logic [CNT_W-1:0] o_rdata
);

    logic [CNT_W-1:0] r_cycle;
    logic [CNT_W-1:0] r_instret;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cycle   <= '0;
            r_instret <= '0;
        end else begin
            r_cycle   <= r_cycle + CNT_W'(1);
            r_instret <= r_instret + CNT_W'(i_retire);
        end
    end

    assign o_rdata = i_sel_instret ? r_instret : r_cycle;

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access unit: address decode, store lanes, load issue
// and one-cycle-later raw return for the load extender.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int DMEM_AW = 14,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               ex_valid,
    input  logic [31:0]        ex_inst,
    input  logic [31:0]        ex_addr,
    input  logic [31:0]        ex_rs2,
    input  logic               inst_retired,
    output logic               dmem_en,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [3:0]         dmem_we,
    output logic [31:0]        dmem_din,
    input  logic [31:0]        dmem_dout,
    output logic               io_re,
    output logic               io_we,
    output logic [31:0]        io_addr,
    output logic [31:0]        io_wdata,
    input  logic [31:0]        io_rdata,
    output logic [31:0]        wb_rdata,
    output logic [31:0]        wb_inst,
    output logic [13:0]        wb_addr,
    output logic               misaligned
);

    logic [6:0]       w_opc;
    logic [1:0]       w_size;
    logic [3:0]       w_hi;
    logic             w_is_ld;
    logic             w_is_st;
    logic             w_access;
    logic             w_mis;
    logic             w_ok;
    logic             w_clr;
    sel_t             w_region;
    sel_t             w_issue_sel;
    logic [CNT_W-1:0] w_cnt_rd;
    logic [31:0]      w_raw;
    logic             w_unused;

    sel_t        r_sel;
    logic [31:0] r_snap;
    logic        r_hold;
    logic [31:0] r_hold_data;
    logic [31:0] r_inst;
    logic [13:0] r_addr;

    assign w_opc    = ex_inst[6:0];
    assign w_size   = ex_inst[13:12];
    assign w_hi     = ex_addr[31:28];
    assign w_is_ld  = (w_opc == OPC_LOAD);
    assign w_is_st  = (w_opc == OPC_STORE);
    assign w_access = !rst && ex_valid && !stall && (w_is_ld || w_is_st);
    assign w_unused = ^{ex_inst[31:14], ex_inst[11:7]};

    always_comb begin
        w_region = SEL_NONE;
        if (w_hi == 4'h1 || w_hi == 4'h3)
            w_region = SEL_DMEM;
        else if (ex_addr == MMIO_CYCLE || ex_addr == MMIO_INSTRET)
            w_region = SEL_CNT;
        else if (w_hi == 4'h8)
            w_region = SEL_IO;
    end

    assign w_mis = w_access &&
                   ((w_size == SZ_HALF && ex_addr[0]) ||
                    (w_size == 2'b10 && ex_addr[1:0] != 2'b00));
    assign w_ok  = w_access && !w_mis;
    assign w_clr = w_ok && w_is_st && (ex_addr == MMIO_CLEAR);

    assign w_issue_sel = (w_ok && w_is_ld) ? w_region : SEL_NONE;

    assign dmem_en    = w_ok && (w_region == SEL_DMEM);
    assign dmem_addr  = ex_addr[DMEM_AW+1:2];
    assign dmem_we    = (w_ok && w_is_st && w_region == SEL_DMEM)
                        ? store_we(w_size, ex_addr[1:0]) : 4'b0000;
    assign dmem_din   = store_data(w_size, ex_rs2);
    assign io_re      = w_ok && w_is_ld && (w_region == SEL_IO);
    assign io_we      = w_ok && w_is_st && (w_region == SEL_IO);
    assign io_addr    = ex_addr;
    assign io_wdata   = ex_rs2;
    assign misaligned = w_mis;

    mmio_counters #(.CNT_W(CNT_W)) u_cnt (
        .clk           (clk),
        .rst           (rst),
        .i_clr         (w_clr),
        .i_retire      (inst_retired),
        .i_sel_instret (ex_addr[2]),
        .o_rdata       (w_cnt_rd)
    );

    always_comb begin
        w_raw = 32'h0;
        case (r_sel)
            SEL_DMEM: w_raw = dmem_dout;
            SEL_CNT:  w_raw = r_snap;
            SEL_IO:   w_raw = io_rdata;
            default:  w_raw = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel       <= SEL_NONE;
            r_snap      <= '0;
            r_hold      <= 1'b0;
            r_hold_data <= '0;
            r_inst      <= NOP_INST;
            r_addr      <= '0;
        end else begin
            if (!stall) begin
                r_sel  <= w_issue_sel;
                r_inst <= w_access ? ex_inst : NOP_INST;
                r_addr <= ex_addr[13:0];
                if (w_issue_sel == SEL_CNT)
                    r_snap <= 32'(w_cnt_rd);
            end
            // Memory output may move under a stall; freeze the first returned word.
            if (stall && !r_hold && r_sel != SEL_NONE) begin
                r_hold      <= 1'b1;
                r_hold_data <= w_raw;
            end else if (!stall) begin
                r_hold <= 1'b0;
            end
        end
    end

    assign wb_rdata = r_hold ? r_hold_data : w_raw;
    assign wb_inst  = r_inst;
    assign wb_addr  = r_addr;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit.
// Inputs change #1 after posedge; outputs are sampled before the next edge.
module tb_mem_access_unit;

    localparam logic [31:0] I_SB = 32'h0000_0023;
    localparam logic [31:0] I_SH = 32'h0000_1023;
    localparam logic [31:0] I_SW = 32'h0000_2023;
    localparam logic [31:0] I_LW = 32'h0000_2003;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        ex_valid;
    logic [31:0] ex_inst;
    logic [31:0] ex_addr;
    logic [31:0] ex_rs2;
    logic        inst_retired;
    logic        dmem_en;
    logic [13:0] dmem_addr;
    logic [3:0]  dmem_we;
    logic [31:0] dmem_din;
    logic [31:0] dmem_dout;
    logic        io_re;
    logic        io_we;
    logic [31:0] io_addr;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata;
    logic [31:0] wb_rdata;
    logic [31:0] wb_inst;
    logic [13:0] wb_addr;
    logic        misaligned;

    int n_asrt = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .ex_valid     (ex_valid),
        .ex_inst      (ex_inst),
        .ex_addr      (ex_addr),
        .ex_rs2       (ex_rs2),
        .inst_retired (inst_retired),
        .dmem_en      (dmem_en),
        .dmem_addr    (dmem_addr),
        .dmem_we      (dmem_we),
        .dmem_din     (dmem_din),
        .dmem_dout    (dmem_dout),
        .io_re        (io_re),
        .io_we        (io_we),
        .io_addr      (io_addr),
        .io_wdata     (io_wdata),
        .io_rdata     (io_rdata),
        .wb_rdata     (wb_rdata),
        .wb_inst      (wb_inst),
        .wb_addr      (wb_addr),
        .misaligned   (misaligned)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] inst,
                         input logic [31:0] addr, input logic [31:0] rs2);
        ex_valid = v;
        ex_inst  = inst;
        ex_addr  = addr;
        ex_rs2   = rs2;
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        inst_retired = 1'b0;
        dmem_dout = 32'h0;
        io_rdata = 32'h0;
        drive(1'b1, I_SW, 32'h1000_0000, 32'h1234_5678);
        #1;
        chk("rst_we", {28'h0, dmem_we}, 32'h0);
        chk("rst_en", {31'h0, dmem_en}, 32'h0);
        tick();
        chk("rst_inst", wb_inst, 32'h0000_0013);
        chk("rst_rdata", wb_rdata, 32'h0);
        chk("rst_addr", {18'h0, wb_addr}, 32'h0);
        tick();
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0);

        // cycle 0..4 retire, then idle up to cycle 8
        inst_retired = 1'b1;
        repeat (5) tick();
        inst_retired = 1'b0;
        repeat (3) tick();
        drive(1'b1, I_LW, 32'h8000_0014, 32'h0);
        tick();
        chk("instret5", wb_rdata, 32'd5);
        drive(1'b1, I_LW, 32'h8000_0010, 32'h0);
        tick();
        chk("cycle9", wb_rdata, 32'd9);
        drive(1'b1, I_SW, 32'h8000_0018, 32'h0000_0077);
        inst_retired = 1'b1;
        #1;
        chk("clr_io_we", {31'h0, io_we}, 32'h1);
        chk("clr_wdata", io_wdata, 32'h0000_0077);
        tick();
        inst_retired = 1'b0;
        drive(1'b1, I_LW, 32'h8000_0010, 32'h0);
        tick();
        chk("cycle_clr", wb_rdata, 32'h0);
        drive(1'b1, I_LW, 32'h8000_0014, 32'h0);
        tick();
        chk("instret_clr", wb_rdata, 32'h0);

        drive(1'b1, I_SB, 32'h1000_0002, 32'h1234_56AB);
        #1;
        chk("sb_we", {28'h0, dmem_we}, 32'h2);
        chk("sb_din", dmem_din, 32'hABAB_ABAB);
        chk("sb_mis", {31'h0, misaligned}, 32'h0);
        chk("sb_en", {31'h0, dmem_en}, 32'h1);
        tick();
        drive(1'b1, I_SH, 32'h1000_0003, 32'h0000_BEEF);
        #1;
        chk("sh_mis_we", {28'h0, dmem_we}, 32'h0);
        chk("sh_mis", {31'h0, misaligned}, 32'h1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        #1;
        chk("mis_pulse", {31'h0, misaligned}, 32'h0);
        tick();
        drive(1'b1, I_SH, 32'h3000_0002, 32'hCAFE_BEEF);
        #1;
        chk("sh_we", {28'h0, dmem_we}, 32'h3);
        chk("sh_din", dmem_din, 32'hBEEF_BEEF);
        tick();
        drive(1'b1, I_SW, 32'h1000_0008, 32'h0102_0304);
        #1;
        chk("sw_we", {28'h0, dmem_we}, 32'hF);
        chk("sw_din", dmem_din, 32'h0102_0304);
        chk("sw_daddr", {18'h0, dmem_addr}, 32'h2);
        tick();
        drive(1'b1, I_LW, 32'h1000_0006, 32'h0);
        #1;
        chk("lw_mis", {31'h0, misaligned}, 32'h1);
        chk("lw_mis_en", {31'h0, dmem_en}, 32'h0);
        tick();

        drive(1'b1, I_LW, 32'h1000_0004, 32'h0);
        #1;
        chk("lw_en", {31'h0, dmem_en}, 32'h1);
        chk("lw_we", {28'h0, dmem_we}, 32'h0);
        chk("lw_daddr", {18'h0, dmem_addr}, 32'h1);
        tick();
        dmem_dout = 32'hDEAD_BEEF;
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        #1;
        chk("lw_rdata", wb_rdata, 32'hDEAD_BEEF);
        chk("lw_waddr", {18'h0, wb_addr}, 32'h4);
        chk("lw_winst", wb_inst, I_LW);
        tick();
        chk("bubble_inst", wb_inst, 32'h0000_0013);

        drive(1'b1, I_LW, 32'h1000_0010, 32'h0);
        tick();
        stall = 1'b1;
        dmem_dout = 32'h1111_1111;
        drive(1'b1, I_LW, 32'h1000_0020, 32'h0);
        #1;
        chk("stl_r1", wb_rdata, 32'h1111_1111);
        chk("stl_en", {31'h0, dmem_en}, 32'h0);
        tick();
        dmem_dout = 32'h2222_2222;
        #1;
        chk("stl_r2", wb_rdata, 32'h1111_1111);
        tick();
        dmem_dout = 32'h3333_3333;
        #1;
        chk("stl_r3", wb_rdata, 32'h1111_1111);
        chk("stl_inst", wb_inst, I_LW);
        chk("stl_addr", {18'h0, wb_addr}, 32'h10);
        tick();
        stall = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        tick();

        drive(1'b1, I_SW, 32'h8000_0100, 32'hFEED_0001);
        #1;
        chk("io_we", {31'h0, io_we}, 32'h1);
        chk("io_addr", io_addr, 32'h8000_0100);
        chk("io_st_en", {31'h0, dmem_en}, 32'h0);
        tick();

        dmem_dout = 32'hFFFF_FFFF;
        io_rdata  = 32'hFFFF_FFFF;
        drive(1'b1, I_LW, 32'h4000_0000, 32'h0);
        #1;
        chk("none_strb", {28'h0, dmem_en, io_re, io_we, |dmem_we}, 32'h0);
        tick();
        chk("none_rdata", wb_rdata, 32'h0);

        drive(1'b1, I_LW, 32'h8000_0200, 32'h0);
        io_rdata = 32'h5A5A_A5A5;
        #1;
        chk("io_re", {31'h0, io_re}, 32'h1);
        tick();
        rst = 1'b1;
        #1;
        chk("io_rdata", wb_rdata, 32'h5A5A_A5A5);
        chk("rst_io_re", {31'h0, io_re}, 32'h0);
        tick();
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        #1;
        chk("rst_mid_rd", wb_rdata, 32'h0);
        chk("rst_mid_in", wb_inst, 32'h0000_0013);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end

endmodule
